decode_stage: RTL
=================

# decode_stage

Instruction-decode pipeline stage wrapped around the 16x16 register file. It drives the two register-file read addresses from the IF/ID instruction and resolves same-cycle writeback bypass and load-use hazards. It registers operands and decoded fields into the ID/EX pipeline register consumed by execute, and back-pressures fetch with a stall.

## Interface
- DATA_W, 16, register/operand width
- REG_AW, 4, register index width (16 registers; register 0 reads as zero)
- STALL_CNT_W, 16, width of saturating stall-cycle counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifid_valid  in  1  IF/ID holds a valid instruction
- ifid_instr  in  DATA_W  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm
- flush  in  1  branch taken in execute; squash instruction in decode
- SrcReg1, SrcReg2  out  REG_AW  register-file read addresses (combinational)
- SrcData1, SrcData2  in  DATA_W  register-file read data
- wb_we, wb_reg, wb_data  in  1/REG_AW/DATA_W  writeback port, shared with register-file DstReg/DstData/WriteReg
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- idex_valid  out  1  ID/EX holds a valid instruction
- idex_opcode, idex_rd  out  4/REG_AW  decoded fields
- idex_op1, idex_op2  out  DATA_W  resolved operand values
- idex_imm  out  8  instr[7:0]
- idex_mem_read, idex_mem_write, idex_reg_write  out  1  control bits
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Source select: SrcReg1 = rs, SrcReg2 = rt; opcode SW (4'b1001) sets SrcReg2 = rd; LLB/LHB (4'b1010/4'b1011) set SrcReg1 = rd.
- Uses: src1 is used by all opcodes except HLT (4'b1111) and branches (4'b1100, 4'b1101). src2 is used only by the R-type opcodes (4'b0000–4'b0111) and SW.
- Operand resolve per source:
  - Register 0 gives 0.
  - If a bypass hit occurs (wb_we && wb_reg == src && src != 0), the operand is wb_data.
  - Otherwise the operand is SrcData.
- Control: mem_read = LW (4'b1000); mem_write = SW; reg_write = opcodes 0000–0111, LW, LLB, LHB, PCS (4'b1110).
- Load-use hazard: idex_valid && idex_mem_read && idex_rd != 0 && idex_rd matches a used source. Result is stall = 1.
- Update priority each edge (highest first):
  1. flush: idex_valid <= 0.
  2. stall: idex_valid <= 0 (bubble), other ID/EX fields don't-care.
  3. Otherwise: load all ID/EX fields; idex_valid <= ifid_valid.
- stall is forced 0 when flush = 1 or ifid_valid = 0.
- stall_count increments on every cycle with stall = 1 and saturates at all-ones.

## Timing
- Decode latency: 1 cycle, from IF/ID presentation to ID/EX outputs.
- Load-use hazard: exactly one bubble. On the next cycle the load sits in EX/MEM, so no further match occurs.
- Reset: idex_valid, idex_opcode, idex_rd, idex_op1, idex_op2, idex_imm, idex_mem_read, idex_mem_write, idex_reg_write and stall_count all go to 0. Reset takes effect immediately, mid-stall included.
- Bypass is same-cycle: a writeback committing on this edge is captured in idex_op* on this same edge.
- Simultaneous flush and stall: flush wins, and stall is deasserted.

## Configuration
- DECODE_BYPASS_EN defined: WB-to-decode bypass as described above.
- DECODE_BYPASS_EN undefined:
  - No bypass mux; operands come from SrcData only.
  - A bypass-hit condition on a used source instead raises stall for that cycle, with a bubble inserted.
  - That stall is counted in stall_count.

## Structure
- Shared package wisc_pkg holds opcode localparams (OP_ADD … OP_HLT) and a typedef idex_t struct for the ID/EX fields.
- One sub-module, hazard_detect: combinational use-decode plus the load-use and (when bypass is disabled) writeback-conflict compare. It produces stall.

## Test plan
- Reset mid-stream: rst high asynchronously → idex_valid = 0 and stall_count = 0 before the next edge.
- ADD R3,R1,R2 with R1=5, R2=7 in the register file → one edge later idex_op1 = 5, idex_op2 = 7, idex_reg_write = 1, idex_rd = 3.
- Bypass, same cycle: wb_we=1, wb_reg=1, wb_data=16'hBEEF while decoding ADD R4,R1,R2 → idex_op1 = 16'hBEEF. With the macro undefined instead: stall = 1 for one cycle, then idex_op1 = 16'hBEEF read from the register file.
- Load-use: LW R5 followed by SUB R6,R5,R0 → stall = 1 for exactly 1 cycle, one idex_valid = 0 bubble, stall_count = 1.
- Flush during a load-use stall → stall = 0, idex_valid = 0 next edge, stall_count unchanged.
- Register 0: ADD R1,R0,R0 with wb_we=1, wb_reg=0, wb_data=16'hFFFF → idex_op1 = idex_op2 = 0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared decode definitions: opcode encodings, ID/EX register layout and small decode helpers.
package wisc_pkg;

    localparam int unsigned DATA_W_P = 16;
    localparam int unsigned REG_AW_P = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_NAND   = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic                valid;
        logic [3:0]          opcode;
        logic [REG_AW_P-1:0] rd;
        logic [DATA_W_P-1:0] op1;
        logic [DATA_W_P-1:0] op2;
        logic [7:0]          imm;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
    } idex_t;

    // R-type ops occupy the lower half of the opcode space
    function automatic logic is_rtype(logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic is_reg_write(logic [3:0] op);
        return is_rtype(op) || (op == OP_LW) || (op == OP_LLB) || (op == OP_LHB) || (op == OP_PCS);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Decode-stage hazard detection: source-use decode, load-use compare and, when
// DECODE_BYPASS_EN is undefined, a writeback-conflict compare (stall instead of bypass).
module hazard_detect
    import wisc_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              ifid_valid,
    input  logic              flush,
    input  logic              idex_valid,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_reg,
    output logic              stall
);

    logic use1, use2, load_use, wb_conflict;

`ifdef DECODE_BYPASS_EN
    // Writeback is forwarded, so it never causes a stall here
    logic unused_wb;
    assign unused_wb   = ^{wb_we, wb_reg};
    assign wb_conflict = 1'b0;
`else
    // Without the bypass mux a same-cycle writeback to a used source must wait one cycle
    assign wb_conflict = wb_we && (wb_reg != '0) &&
                         ((use1 && (wb_reg == src1)) || (use2 && (wb_reg == src2)));
`endif

    // Source-use decode and load-use compare; flush or an empty IF/ID never stalls
    always_comb begin
        use1     = !((opcode == OP_HLT) || (opcode == OP_B) || (opcode == OP_BR));
        use2     = is_rtype(opcode) || (opcode == OP_SW);
        load_use = idex_valid && idex_mem_read && (idex_rd != '0) &&
                   ((use1 && (idex_rd == src1)) || (use2 && (idex_rd == src2)));
        stall    = ifid_valid && !flush && (load_use || wb_conflict);
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file address select, operand resolve (optional
// WB bypass under DECODE_BYPASS_EN), hazard stall and the ID/EX pipeline register.
module decode_stage
    import wisc_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_P,
    parameter int unsigned REG_AW      = REG_AW_P,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ifid_valid,
    input  logic [DATA_W-1:0]      ifid_instr,
    input  logic                   flush,
    output logic [REG_AW-1:0]      SrcReg1,
    output logic [REG_AW-1:0]      SrcReg2,
    input  logic [DATA_W-1:0]      SrcData1,
    input  logic [DATA_W-1:0]      SrcData2,
    input  logic                   wb_we,
    input  logic [REG_AW-1:0]      wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stall,
    output logic                   idex_valid,
    output logic [3:0]             idex_opcode,
    output logic [REG_AW-1:0]      idex_rd,
    output logic [DATA_W-1:0]      idex_op1,
    output logic [DATA_W-1:0]      idex_op2,
    output logic [7:0]             idex_imm,
    output logic                   idex_mem_read,
    output logic                   idex_mem_write,
    output logic                   idex_reg_write,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [3:0]             opcode;
    logic [REG_AW-1:0]      rd, rs, rt;
    logic [DATA_W-1:0]      op1, op2;
    idex_t                  idex_d, idex_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    assign opcode = ifid_instr[15:12];
    assign rd     = ifid_instr[11:8];
    assign rs     = ifid_instr[7:4];
    assign rt     = ifid_instr[3:0];

    // Read-address select: SW reads its store data from rd, LLB/LHB modify rd in place
    always_comb begin
        SrcReg1 = ((opcode == OP_LLB) || (opcode == OP_LHB)) ? rd : rs;
        SrcReg2 = (opcode == OP_SW) ? rd : rt;
    end

`ifndef DECODE_BYPASS_EN
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
`endif

    // Operand resolve: register 0 forced to zero, otherwise bypass (if built) or regfile data
    always_comb begin
        op1 = SrcData1;
        op2 = SrcData2;
`ifdef DECODE_BYPASS_EN
        if (wb_we && (wb_reg == SrcReg1)) op1 = wb_data;
        if (wb_we && (wb_reg == SrcReg2)) op2 = wb_data;
`endif
        if (SrcReg1 == '0) op1 = '0;
        if (SrcReg2 == '0) op2 = '0;
    end

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .opcode        (opcode),
        .src1          (SrcReg1),
        .src2          (SrcReg2),
        .ifid_valid    (ifid_valid),
        .flush         (flush),
        .idex_valid    (idex_q.valid),
        .idex_mem_read (idex_q.mem_read),
        .idex_rd       (idex_q.rd),
        .wb_we         (wb_we),
        .wb_reg        (wb_reg),
        .stall         (stall)
    );

    // ID/EX next state: flush or stall insert a bubble, otherwise load the decoded instruction
    always_comb begin
        idex_d = idex_q;
        if (flush || stall) begin
            idex_d.valid = 1'b0;
        end else begin
            idex_d.valid     = ifid_valid;
            idex_d.opcode    = opcode;
            idex_d.rd        = rd;
            idex_d.op1       = op1;
            idex_d.op2       = op2;
            idex_d.imm       = ifid_instr[7:0];
            idex_d.mem_read  = (opcode == OP_LW);
            idex_d.mem_write = (opcode == OP_SW);
            idex_d.reg_write = is_reg_write(opcode);
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    // Pipeline register and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign idex_valid     = idex_q.valid;
    assign idex_opcode    = idex_q.opcode;
    assign idex_rd        = idex_q.rd;
    assign idex_op1       = idex_q.op1;
    assign idex_op2       = idex_q.op2;
    assign idex_imm       = idex_q.imm;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_mem_write = idex_q.mem_write;
    assign idex_reg_write = idex_q.reg_write;
    assign stall_count    = stall_cnt_q;

endmodule
